// File: rtl/vga_pkg.sv
// Shared definitions for the VGA layer compositor.
//
// Holds the layer-array geometry (NUM_LAYERS, PRIO_W, IDX_W, RGB_W), a few
// named colours, the configuration FSM state encoding and the candidate
// record passed between levels of the priority compare tree.
package vga_pkg;

    localparam int NUM_LAYERS  = 16;
    localparam int PRIO_W      = 4;
    localparam int IDX_W       = $clog2(NUM_LAYERS);
    localparam int RGB_W       = 12;
    localparam int TREE_LEVELS = $clog2(NUM_LAYERS);

    localparam logic [RGB_W-1:0] WHITE = 12'hFFF;
    localparam logic [RGB_W-1:0] GREEN = 12'h0F0;
    localparam logic [RGB_W-1:0] BLUE  = 12'h00F;

    typedef logic [RGB_W-1:0]  rgb_t;
    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic [1:0] {
        CFG_IDLE    = 2'd0,
        CFG_PENDING = 2'd1,
        CFG_COMMIT  = 2'd2
    } cfg_state_t;

    // One contender at some level of the compare tree.
    typedef struct packed {
        logic  hit;
        prio_t prio;
        idx_t  idx;
        rgb_t  rgb;
    } cand_t;

    // 'hi' always comes from the subtree holding the higher layer indices,
    // so using >= hands equal-priority ties to the higher index.
    function automatic cand_t pick_winner(input cand_t lo, input cand_t hi);
        if (hi.hit && (!lo.hit || hi.prio >= lo.prio)) begin
            return hi;
        end
        return lo;
    endfunction

endpackage

// File: rtl/prio_select_tree.sv
// Combinational priority selector for the layer compositor.
//
// A log2(NUM_LAYERS)-level binary compare tree. Each node keeps the opaque
// candidate with the higher priority, preferring the higher layer index on
// equal priority. Layers whose hit bit is clear never win.
//
// Ports:
//   hit      in   NUM_LAYERS         per-layer "enabled and opaque" flags
//   prio     in   PRIO_W x NUM_LAYERS per-layer priority
//   rgb      in   RGB_W  x NUM_LAYERS per-layer colour
//   win_idx  out  IDX_W              index of the winning layer
//   win_rgb  out  RGB_W              colour of the winning layer
//   any_hit  out  1                  some layer had its hit bit set
module prio_select_tree
    import vga_pkg::*;
(
    input  logic [NUM_LAYERS-1:0] hit,
    input  logic [PRIO_W-1:0]     prio [NUM_LAYERS],
    input  logic [RGB_W-1:0]      rgb  [NUM_LAYERS],
    output logic [IDX_W-1:0]      win_idx,
    output logic [RGB_W-1:0]      win_rgb,
    output logic                  any_hit
);

    // lvl[0] holds the leaves; lvl[l] holds NUM_LAYERS >> l survivors.
    cand_t lvl [TREE_LEVELS+1][NUM_LAYERS];

    always_comb begin
        // NOTE: every slot gets a value before the tree is built, so the
        // unused upper slots of each level cannot infer latches.
        for (int l = 0; l <= TREE_LEVELS; l++) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                lvl[l][i] = '0;
            end
        end

        for (int i = 0; i < NUM_LAYERS; i++) begin
            lvl[0][i].hit  = hit[i];
            lvl[0][i].prio = prio[i];
            lvl[0][i].idx  = IDX_W'(i);
            lvl[0][i].rgb  = rgb[i];
        end

        for (int l = 1; l <= TREE_LEVELS; l++) begin
            for (int i = 0; i < (NUM_LAYERS >> l); i++) begin
                lvl[l][i] = pick_winner(lvl[l-1][2*i], lvl[l-1][2*i+1]);
            end
        end
    end

    assign win_idx = lvl[TREE_LEVELS][0].idx;
    assign win_rgb = lvl[TREE_LEVELS][0].rgb;
    assign any_hit = lvl[TREE_LEVELS][0].hit;

endmodule

// File: rtl/layer_priority_arbiter.sv
// Runtime-configurable, pipelined layer compositor for the VGA output.
//
// Picks one winning layer per pixel from NUM_LAYERS colour buses, using
// per-layer priority and enable. Configuration writes land in a shadow
// copy and are committed to the active copy only at frame start, so a
// frame is always composited with a single configuration.
//
// Pipeline (advances only when pix_en is high, two ticks of latency):
//   S1: hit[i] = enable[i] & (layer i != background), plus colours,
//       background and bright.
//   S2: winner selection -> rgb_out / win_layer / win_valid / bright_out.
//
// Ports:
//   ClkPort      in   1              system clock
//   Reset        in   1              synchronous, active-high reset
//   pix_en       in   1              pixel-clock enable
//   frame_start  in   1              frame start pulse, qualified by pix_en
//   bright       in   1              display-active flag aligned with layer_rgb
//   background   in   RGB_W          transparent key colour
//   layer_rgb    in   NUM_LAYERS*12  layer i at bits [12i+11:12i]
//   cfg_valid    in   1              configuration write request
//   cfg_ready    out  1              write accepted when valid & ready
//   cfg_layer    in   IDX_W          target layer of the write
//   cfg_prio     in   PRIO_W         new priority for the target layer
//   cfg_en       in   1              new enable for the target layer
//   rgb_out      out  RGB_W          composited pixel colour
//   bright_out   out  1              bright aligned with rgb_out
//   win_layer    out  IDX_W          winning layer, 0 when win_valid is low
//   win_valid    out  1              some enabled layer was opaque
module layer_priority_arbiter
    import vga_pkg::*;
(
    input  logic                        ClkPort,
    input  logic                        Reset,
    input  logic                        pix_en,
    input  logic                        frame_start,
    input  logic                        bright,
    input  logic [RGB_W-1:0]            background,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [IDX_W-1:0]            cfg_layer,
    input  logic [PRIO_W-1:0]           cfg_prio,
    input  logic                        cfg_en,
    output logic [RGB_W-1:0]            rgb_out,
    output logic                        bright_out,
    output logic [IDX_W-1:0]            win_layer,
    output logic                        win_valid
);

    rgb_t                  layer_in [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] hit_now;

    logic [NUM_LAYERS-1:0] en_active;
    logic [NUM_LAYERS-1:0] en_shadow;
    logic [PRIO_W-1:0]     prio_active [NUM_LAYERS];
    logic [PRIO_W-1:0]     prio_shadow [NUM_LAYERS];
    cfg_state_t            cfg_state;
    logic                  cfg_accept;
    logic                  cfg_in_range;

    logic [NUM_LAYERS-1:0] s1_hit;
    rgb_t                  s1_rgb [NUM_LAYERS];
    rgb_t                  s1_bg;
    logic                  s1_bright;

    idx_t                  win_idx;
    rgb_t                  win_rgb;
    logic                  any_hit;

    // Unpack the layer bus and flag layers that are enabled and opaque.
    always_comb begin
        hit_now = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_in[i] = layer_rgb[i*RGB_W +: RGB_W];
            hit_now[i]  = en_active[i] & (layer_in[i] != background);
        end
    end

    // cfg_ready is low only in COMMIT, so no write can race the copy.
    assign cfg_accept   = cfg_valid & cfg_ready;
    // Widened by one bit so the check stays meaningful for any NUM_LAYERS.
    assign cfg_in_range = ({1'b0, cfg_layer} < (IDX_W+1)'(NUM_LAYERS));

    // Configuration FSM with shadow and active register banks.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            cfg_state <= CFG_IDLE;
            cfg_ready <= 1'b1;
            en_active <= '1;
            en_shadow <= '1;
            // NOTE: the per-layer arrays are ordinary flops, not a RAM, and
            // must be reset: the reset priority order (higher index wins)
            // is architectural state the display relies on.
            for (int i = 0; i < NUM_LAYERS; i++) begin
                prio_active[i] <= PRIO_W'(i);
                prio_shadow[i] <= PRIO_W'(i);
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples the pre-edge values, whatever the order of
            // statements below.
            if (cfg_accept && cfg_in_range) begin
                en_shadow[cfg_layer]   <= cfg_en;
                prio_shadow[cfg_layer] <= cfg_prio;
            end

            case (cfg_state)
                CFG_IDLE: begin
                    if (cfg_accept && cfg_in_range) begin
                        cfg_state <= CFG_PENDING;
                    end
                end
                CFG_PENDING: begin
                    // A write accepted on this same edge is already in the
                    // shadow by the time COMMIT copies it.
                    if (frame_start && pix_en) begin
                        cfg_state <= CFG_COMMIT;
                        cfg_ready <= 1'b0;
                    end
                end
                CFG_COMMIT: begin
                    en_active   <= en_shadow;
                    prio_active <= prio_shadow;
                    cfg_state   <= CFG_IDLE;
                    cfg_ready   <= 1'b1;
                end
                default: begin
                    cfg_state <= CFG_IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    prio_select_tree u_tree (
        .hit     (s1_hit),
        .prio    (prio_active),
        .rgb     (s1_rgb),
        .win_idx (win_idx),
        .win_rgb (win_rgb),
        .any_hit (any_hit)
    );

    // Two-stage pixel pipeline, frozen on cycles without pix_en.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            s1_hit     <= '0;
            s1_bg      <= '0;
            s1_bright  <= 1'b0;
            rgb_out    <= '0;
            bright_out <= 1'b0;
            win_layer  <= '0;
            win_valid  <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                s1_rgb[i] <= '0;
            end
        end else if (pix_en) begin
            s1_hit     <= hit_now;
            s1_rgb     <= layer_in;
            s1_bg      <= background;
            s1_bright  <= bright;
            bright_out <= s1_bright;
            if (s1_bright) begin
                rgb_out   <= any_hit ? win_rgb : s1_bg;
                win_layer <= any_hit ? win_idx : '0;
                win_valid <= any_hit;
            end else begin
                // Blanking: drive black regardless of layer contents.
                rgb_out   <= '0;
                win_layer <= '0;
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// Self-checking bench for layer_priority_arbiter, with a behavioural model
// of the priority rules, the 2-tick pipeline and the shadow/commit scheme.
module tb_layer_priority_arbiter;
    import vga_pkg::*;

    typedef logic [NUM_LAYERS*RGB_W-1:0] layers_t;

    typedef struct packed {
        logic [RGB_W-1:0] rgb;
        logic             bright;
        logic             valid;
        logic [IDX_W-1:0] idx;
    } res_t;

    logic               ClkPort = 1'b0;
    logic               Reset = 1'b1;
    logic               pix_en = 1'b0;
    logic               frame_start = 1'b0;
    logic               bright = 1'b0;
    logic [RGB_W-1:0]   background = WHITE;
    layers_t            layer_rgb = '0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [IDX_W-1:0]   cfg_layer = '0;
    logic [PRIO_W-1:0]  cfg_prio = '0;
    logic               cfg_en = 1'b0;
    logic [RGB_W-1:0]   rgb_out;
    logic               bright_out;
    logic [IDX_W-1:0]   win_layer;
    logic               win_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit   m_en   [NUM_LAYERS];
    int   m_prio [NUM_LAYERS];
    bit   s_en   [NUM_LAYERS];
    int   s_prio [NUM_LAYERS];
    bit   m_pending;
    bit   m_commit;
    res_t pipe_q [$];
    res_t m_out;

    layer_priority_arbiter dut (
        .ClkPort     (ClkPort),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .frame_start (frame_start),
        .bright      (bright),
        .background  (background),
        .layer_rgb   (layer_rgb),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_layer   (cfg_layer),
        .cfg_prio    (cfg_prio),
        .cfg_en      (cfg_en),
        .rgb_out     (rgb_out),
        .bright_out  (bright_out),
        .win_layer   (win_layer),
        .win_valid   (win_valid)
    );

    always #5 ClkPort = ~ClkPort;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, got no summary, expected one");
        $fatal(1, "timeout");
    end

    function automatic res_t dut_out();
        return {rgb_out, bright_out, win_valid, win_layer};
    endfunction

    // Winner by rule: scan priorities from highest down, and within one
    // priority scan indices from highest down; the first opaque enabled
    // layer found wins.
    function automatic res_t model_pixel(input layers_t lr, input rgb_t bg, input logic br);
        res_t r = '0;
        bit found = 0;
        r.bright = br;
        if (!br) return r;
        r.rgb = bg;
        for (int p = (1 << PRIO_W) - 1; p >= 0; p--) begin
            for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                if (!found && m_en[i] && lr[i*RGB_W +: RGB_W] != bg && m_prio[i] == p) begin
                    found   = 1;
                    r.rgb   = lr[i*RGB_W +: RGB_W];
                    r.valid = 1'b1;
                    r.idx   = IDX_W'(i);
                end
            end
        end
        return r;
    endfunction

    function automatic layers_t two_layers(input int a, input rgb_t ca, input int b, input rgb_t cb);
        layers_t v;
        for (int i = 0; i < NUM_LAYERS; i++) v[i*RGB_W +: RGB_W] = WHITE;
        v[a*RGB_W +: RGB_W] = ca;
        v[b*RGB_W +: RGB_W] = cb;
        return v;
    endfunction

    function automatic layers_t random_layers(input rgb_t bg);
        layers_t v;
        rgb_t c;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            c = rgb_t'($urandom);
            if (c == bg) c = c ^ 12'h001;
            v[i*RGB_W +: RGB_W] = ($urandom_range(0, 2) == 0) ? c : bg;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_LAYERS; i++) begin
            m_en[i]   = 1'b1;
            s_en[i]   = 1'b1;
            m_prio[i] = i % (1 << PRIO_W);
            s_prio[i] = i % (1 << PRIO_W);
        end
        m_pending = 0;
        m_commit  = 0;
        pipe_q.delete();
        pipe_q.push_back('0);
        m_out = '0;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        cfg_valid = 1'b0;
        pix_en = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(posedge ClkPort);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    // One ClkPort cycle; the model follows the same edge.
    task automatic step(input logic pe, input logic fs);
        bit acc;
        bit in_range;
        pix_en = pe;
        frame_start = fs;
        acc = cfg_valid && !m_commit;
        in_range = int'(cfg_layer) < NUM_LAYERS;
        @(posedge ClkPort);
        if (pe) begin
            pipe_q.push_back(model_pixel(layer_rgb, background, bright));
            m_out = pipe_q.pop_front();
        end
        if (m_commit) begin
            m_en = s_en;
            m_prio = s_prio;
            m_commit = 0;
        end else begin
            if (acc && in_range) begin
                s_en[int'(cfg_layer)]   = cfg_en;
                s_prio[int'(cfg_layer)] = int'(cfg_prio);
            end
            if (m_pending && pe && fs) begin
                m_pending = 0;
                m_commit  = 1;
            end else if (acc && in_range) begin
                m_pending = 1;
            end
        end
        #1;
        pix_en = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pixel(input layers_t lr, input logic br, input logic fs);
        layer_rgb = lr;
        bright = br;
        step(1'b1, fs);
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic cfg_write(input int layer, input int prio, input logic en);
        bit go;
        cfg_valid = 1'b1;
        cfg_layer = IDX_W'(layer);
        cfg_prio  = PRIO_W'(prio);
        cfg_en    = en;
        for (int k = 0; k < 8; k++) begin
            go = !m_commit;
            step(1'b0, 1'b0);
            if (go) break;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (dut_out() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 00000", dut_out());
        end
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cfg_ready: got %b, expected 1", cfg_ready);
        end
    endtask

    task automatic test_basic();
        layers_t lr = two_layers(3, GREEN, 7, BLUE);
        res_t exp = '{rgb: BLUE, bright: 1'b1, valid: 1'b1, idx: 4'd7};
        background = WHITE;
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (win_valid !== 1'b0 || dut_out() !== m_out) begin
            n_fail++;
            $display("FAIL basic_latency1: got %h, expected %h", dut_out(), m_out);
        end
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL basic_layer7: got %h, expected %h", dut_out(), exp);
        end
    endtask

    task automatic test_prio_commit();
        layers_t lr = two_layers(3, GREEN, 7, BLUE);
        res_t exp = '{rgb: GREEN, bright: 1'b1, valid: 1'b1, idx: 4'd3};
        cfg_write(3, 15, 1'b1);
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (win_layer !== 4'd7 || rgb_out !== BLUE) begin
            n_fail++;
            $display("FAIL prio_shadowed: got idx=%0d rgb=%h, expected idx=7 rgb=%h", win_layer, rgb_out, BLUE);
        end
        pixel(lr, 1'b0, 1'b1);
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== 17'd0 || dut_out() !== m_out) begin
            n_fail++;
            $display("FAIL prio_blank_fs: got %h, expected 00000", dut_out());
        end
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL prio_committed: got %h, expected %h", dut_out(), exp);
        end
    endtask

    task automatic test_disable();
        layers_t lr = two_layers(3, GREEN, 7, BLUE);
        res_t exp = '{rgb: WHITE, bright: 1'b1, valid: 1'b0, idx: 4'd0};
        cfg_write(7, 7, 1'b0);
        cfg_write(3, 15, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (win_layer !== 4'd3 || win_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_shadowed: got idx=%0d v=%b, expected idx=3 v=1", win_layer, win_valid);
        end
        pixel(lr, 1'b0, 1'b1);
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL disable_all: got %h, expected %h", dut_out(), exp);
        end
    endtask

    task automatic test_bright();
        layers_t lr = two_layers(1, GREEN, 9, BLUE);
        res_t exp = '{rgb: BLUE, bright: 1'b1, valid: 1'b1, idx: 4'd9};
        pixel(lr, 1'b0, 1'b0);
        pixel(lr, 1'b0, 1'b0);
        n_tests++;
        if (dut_out() !== 17'd0) begin
            n_fail++;
            $display("FAIL bright_low: got %h, expected 00000", dut_out());
        end
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL bright_high: got %h, expected %h", dut_out(), exp);
        end
    endtask

    task automatic test_cfg_stall();
        layers_t lr;
        res_t exp;
        cfg_write(5, 9, 1'b1);
        // Write held across the frame_start tick, then a second one that
        // meets the COMMIT cycle.
        cfg_valid = 1'b1;
        cfg_layer = 4'd2;
        cfg_prio  = 4'd14;
        cfg_en    = 1'b1;
        bright    = 1'b0;
        step(1'b1, 1'b1);
        n_tests++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_commit_ready: got %b, expected 0", cfg_ready);
        end
        cfg_layer = 4'd4;
        cfg_prio  = 4'd13;
        step(1'b0, 1'b0);
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_one_cycle: got %b, expected 1", cfg_ready);
        end
        step(1'b0, 1'b0);
        cfg_valid = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        lr = two_layers(2, GREEN, 5, BLUE);
        lr[4*RGB_W +: RGB_W] = 12'h123;
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        exp = '{rgb: GREEN, bright: 1'b1, valid: 1'b1, idx: 4'd2};
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL stall_same_cycle_write: got %h, expected %h", dut_out(), exp);
        end
        pixel(lr, 1'b0, 1'b1);
        lr = two_layers(4, 12'h123, 5, BLUE);
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        exp = '{rgb: 12'h123, bright: 1'b1, valid: 1'b1, idx: 4'd4};
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL stall_write_kept: got %h, expected %h", dut_out(), exp);
        end
    endtask

    task automatic test_tie_boundary();
        layers_t lr = two_layers(0, GREEN, 15, BLUE);
        res_t exp = '{rgb: BLUE, bright: 1'b1, valid: 1'b1, idx: 4'd15};
        cfg_write(15, 0, 1'b1);
        cfg_write(0, 0, 1'b1);
        pixel(lr, 1'b0, 1'b1);
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL tie_high_index: got %h, expected %h", dut_out(), exp);
        end
        cfg_write(15, 0, 1'b0);
        pixel(lr, 1'b0, 1'b1);
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        exp = '{rgb: GREEN, bright: 1'b1, valid: 1'b1, idx: 4'd0};
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL layer15_disabled: got %h, expected %h", dut_out(), exp);
        end
    endtask

    task automatic test_pix_en_hold();
        for (int k = 0; k < 8; k++) begin
            layer_rgb = random_layers(WHITE);
            bright = 1'b1;
            step(1'b1, 1'b0);
            for (int c = 0; c < 3; c++) begin
                layer_rgb  = random_layers(WHITE);
                bright     = 1'($urandom_range(0, 1));
                step(1'b0, 1'b0);
                n_tests++;
                if (dut_out() !== m_out) begin
                    n_fail++;
                    $display("FAIL hold_no_pix_en: got %h, expected %h", dut_out(), m_out);
                end
            end
        end
    endtask

    task automatic test_reset_pending();
        layers_t lr = two_layers(3, GREEN, 15, BLUE);
        res_t exp = '{rgb: BLUE, bright: 1'b1, valid: 1'b1, idx: 4'd15};
        cfg_write(3, 15, 1'b1);
        cfg_write(15, 0, 1'b0);
        apply_reset();
        n_tests++;
        if (cfg_ready !== 1'b1 || dut_out() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_pending_state: got ready=%b out=%h, expected ready=1 out=00000", cfg_ready, dut_out());
        end
        pixel(lr, 1'b0, 1'b1);
        pixel(lr, 1'b1, 1'b0);
        pixel(lr, 1'b1, 1'b0);
        n_tests++;
        if (dut_out() !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL reset_discard_shadow: got %h, expected %h", dut_out(), exp);
        end
    endtask

    task automatic test_random();
        rgb_t bg;
        for (int k = 0; k < 400; k++) begin
            bg = ($urandom_range(0, 3) == 0) ? rgb_t'($urandom) : WHITE;
            background = bg;
            if (k % 25 == 0) begin
                pixel(random_layers(bg), 1'b0, 1'b1);
            end else begin
                pixel(random_layers(bg), 1'($urandom_range(0, 4) != 0), 1'b0);
            end
            n_tests++;
            if (dut_out() !== m_out) begin
                n_fail++;
                $display("FAIL random_pixel_%0d: got %h, expected %h", k, dut_out(), m_out);
            end
            if ($urandom_range(0, 4) == 0) begin
                cfg_write($urandom_range(0, NUM_LAYERS - 1), $urandom_range(0, (1 << PRIO_W) - 1),
                          1'($urandom_range(0, 3) != 0));
                n_tests++;
                if (cfg_ready !== !m_commit) begin
                    n_fail++;
                    $display("FAIL random_cfg_ready_%0d: got %b, expected %b", k, cfg_ready, !m_commit);
                end
            end
        end
        background = WHITE;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_prio_commit();
        test_disable();
        test_bright();
        test_cfg_stall();
        test_tie_boundary();
        test_pix_en_hold();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
